// File: rtl/clb_ff_bank_pkg.sv
// Shared constants for the CLB flip-flop bank: configuration chain bit map
// and chain-length helper.
package clb_ff_bank_pkg;

    localparam int CFG_EN_USE   = 0;
    localparam int CFG_SR_USE   = 1;
    localparam int CFG_SR_VAL   = 2;
    localparam int CFG_SHIFT    = 3;
    localparam int CFG_INIT_LSB = 4;

    // Four control bits followed by one init bit per flop.
    function automatic int cfg_bits(input int width);
        return width + 4;
    endfunction

endpackage

// File: rtl/clb_ff_bank_if.sv
// Data-side bus of the flip-flop bank: LUT-facing inputs and registered outputs.
// WIDTH must match the WIDTH of the clb_ff_bank it is connected to.
interface clb_ff_bank_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] ff_D;
    logic [WIDTH-1:0] ff_en;
    logic             ff_sr;
    logic [WIDTH-1:0] ff_Q;

    modport master (output ff_D, ff_en, ff_sr, input ff_Q);
    modport slave  (input ff_D, ff_en, ff_sr, output ff_Q);
endinterface

// File: rtl/clb_ff_bank_ccff.sv
// Configuration shift chain. Shifts toward the MSB while config_enable is high;
// reset only clears the chain when it coincides with config_enable.
module clb_ff_bank_ccff #(
    parameter int CFG_BITS = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                config_enable,
    input  logic                ccff_head,
    output logic                ccff_tail,
    output logic [CFG_BITS-1:0] cfg
);

    logic [CFG_BITS-1:0] cfg_d, cfg_q;

    always_comb begin
        cfg_d = cfg_q;
        if (config_enable)
            cfg_d = {cfg_q[CFG_BITS-2:0], ccff_head};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            if (config_enable)
                cfg_q <= '0;
        end else begin
            cfg_q <= cfg_d;
        end
    end

    assign cfg       = cfg_q;
    assign ccff_tail = cfg_q[CFG_BITS-1];

endmodule

// File: rtl/clb_ff_bank.sv
// WIDTH-bit flip-flop bank with configurable clock-enable, local set/reset,
// shift-register mode and per-bit reset value, programmed via a serial chain.
module clb_ff_bank
    import clb_ff_bank_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          set,
    input  logic          config_enable,
    input  logic          ccff_head,
    output logic          ccff_tail,
    clb_ff_bank_if.slave  bus
);

    localparam int CFG_BITS = cfg_bits(WIDTH);

    logic [CFG_BITS-1:0] cfg;
    logic                en_use, sr_use, sr_val, shift_mode;
    logic [WIDTH-1:0]    init;
    logic [WIDTH-1:0]    ff_q_d, ff_q_q;

    clb_ff_bank_ccff #(.CFG_BITS(CFG_BITS)) u_ccff (
        .clk           (clk),
        .reset         (reset),
        .config_enable (config_enable),
        .ccff_head     (ccff_head),
        .ccff_tail     (ccff_tail),
        .cfg           (cfg)
    );

    assign en_use     = cfg[CFG_EN_USE];
    assign sr_use     = cfg[CFG_SR_USE];
    assign sr_val     = cfg[CFG_SR_VAL];
    assign shift_mode = cfg[CFG_SHIFT];
    assign init       = cfg[CFG_INIT_LSB +: WIDTH];

    // Non-reset priority: config hold > set > local sr > data load.
    always_comb begin
        ff_q_d = ff_q_q;
        if (config_enable) begin
            ff_q_d = ff_q_q;
        end else if (set) begin
            ff_q_d = '1;
        end else if (sr_use && bus.ff_sr) begin
            ff_q_d = {WIDTH{sr_val}};
        end else if (!shift_mode) begin
            for (int i = 0; i < WIDTH; i++)
                if (!en_use || bus.ff_en[i])
                    ff_q_d[i] = bus.ff_D[i];
        end else if (!en_use || bus.ff_en[0]) begin
            ff_q_d = {ff_q_q[WIDTH-2:0], bus.ff_D[0]};
        end
    end

    // Reset loads init from the current cfg, or zero when the chain is being cleared.
    always_ff @(posedge clk) begin
        if (reset)
            ff_q_q <= config_enable ? '0 : init;
        else
            ff_q_q <= ff_q_d;
    end

    assign bus.ff_Q = ff_q_q;

endmodule
